serial_tx_fifo: RTL and testbench

Parametrised UART-style serial transmitter with a runtime baud divisor, selectable parity, 1 or 2 stop bits, and a small input FIFO. Producers push words through a valid/ready handshake. The block serialises each word LSB-first onto a single idle-high line. It sits in the io layer and supersedes the fixed-frame, single-word transmitter for links that need back-to-back frames and configurable framing.

---
 rtl/serial_tx_fifo.sv | 258 +++++++++++++++++++++++++
 tb/tb_serial_tx_fifo.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_fifo.sv
// serial_tx_fifo
//   UART-style serial transmitter fed by a small synchronous FIFO. Words are
//   pushed with a valid/ready handshake and sent LSB-first on an idle-high
//   line as: start(0), Width data bits, optional parity, 1 or 2 stop bits.
//   Each bit lasts div+1 clock cycles. Divisor, parity mode and stop count are
//   captured when a word leaves the FIFO, so they stay fixed for that frame.
//   Frames go out back-to-back when the FIFO still holds data at the end of a stop bit.
//
// Optional build macro:
//   SERIAL_TX_BREAK_EN - adds input brk. A break holds tx low while the
//   transmitter is idle. It waits for any frame in progress to finish first.
//   After the break ends, the line stays high for one bit period before the next start bit.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active low
//   div          bit period minus one, in clk cycles
//   parity_mode  00 none, 01 even, 10 odd, 11 none
//   stop2        1 = two stop bits, 0 = one
//   d / d_valid  producer data word and its valid strobe
//   d_ready      FIFO not full
//   brk          (SERIAL_TX_BREAK_EN only) line break request
//   tx           serial output, idle high
//   busy         FIFO non-empty, frame in progress, or break active
//   level        FIFO occupancy
module serial_tx_fifo #(
  parameter int Width         = 8,
  parameter int DivWidth      = 16,
  parameter int FifoDepthLog2 = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DivWidth-1:0]      div,
  input  logic [1:0]               parity_mode,
  input  logic                     stop2,
  input  logic [Width-1:0]         d,
  input  logic                     d_valid,
`ifdef SERIAL_TX_BREAK_EN
  input  logic                     brk,
`endif
  output logic                     d_ready,
  output logic                     tx,
  output logic                     busy,
  output logic [FifoDepthLog2:0]   level
);

  localparam int Depth = 1 << FifoDepthLog2;
  localparam int IdxW  = (Width > 1) ? $clog2(Width) : 1;
  localparam logic [FifoDepthLog2:0] LevelFull = (FifoDepthLog2 + 1)'(Depth);
  localparam logic [IdxW-1:0]        LastIdx   = IdxW'(Width - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [Width-1:0]         r_mem [Depth];
  logic [FifoDepthLog2-1:0] r_wr_ptr;
  logic [FifoDepthLog2-1:0] r_rd_ptr;
  logic [FifoDepthLog2:0]   r_level;

  // Frame engine
  state_t              r_state;
  logic                r_tx;
  logic [DivWidth-1:0] r_timer;
  logic [DivWidth-1:0] r_div;
  logic [IdxW-1:0]     r_bit_idx;
  logic [Width-1:0]    r_shift;
  logic                r_par_en;
  logic                r_par_bit;
  logic                r_stop2;
  logic                r_stop_cnt;   // set once the first of two stop bits is done

  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_bit_end;
  logic             w_stop_end;
  logic             w_idle_block;   // something other than an empty FIFO keeps IDLE from popping
  logic             w_stop_block;   // suppresses the back-to-back pop at the end of a stop bit
  logic             w_brk_busy;
  logic [Width-1:0] w_head;
  logic [Width-1:0] w_shift_next;

  assign w_full       = (r_level == LevelFull);
  assign w_push       = d_valid && !w_full;   // ready depends only on full, never on a same-cycle pop
  assign w_head       = r_mem[r_rd_ptr];
  assign w_shift_next = r_shift >> 1;
  assign w_bit_end    = (r_timer == r_div);
  assign w_stop_end   = (r_state == S_STOP) && w_bit_end && (!r_stop2 || r_stop_cnt);

`ifdef SERIAL_TX_BREAK_EN
  logic r_brk_hold;   // break was seen while idle; line is being held low
  logic r_brk_gap;    // break just ended; line is held high for one bit period
  logic w_gap_wait;

  assign w_gap_wait   = r_brk_gap && (r_timer != div);
  assign w_idle_block = brk || r_brk_hold || w_gap_wait;
  assign w_stop_block = brk;
  assign w_brk_busy   = r_brk_hold || r_brk_gap;
`else
  assign w_idle_block = 1'b0;
  assign w_stop_block = 1'b0;
  assign w_brk_busy   = 1'b0;
`endif

  // A pop happens either from IDLE or directly at the end of the last stop
  // bit. In the second case there is no idle cycle between frames.
  assign w_pop = (r_level != '0) &&
                 (((r_state == S_IDLE) && !w_idle_block) ||
                  (w_stop_end && !w_stop_block));

  assign d_ready = !w_full;
  assign tx      = r_tx;
  assign level   = r_level;
  assign busy    = (r_state != S_IDLE) || (r_level != '0) || w_brk_busy;

  // NOTE: storage arrays carry no reset; only pointers and level define
  // validity, so the RAM can map onto plain memory cells.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= d;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + FifoDepthLog2'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FifoDepthLog2'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (FifoDepthLog2 + 1)'(1);
        2'b01:   r_level <= r_level - (FifoDepthLog2 + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_tx       <= 1'b1;
      r_timer    <= '0;
      r_div      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_cnt <= 1'b0;
`ifdef SERIAL_TX_BREAK_EN
      r_brk_hold <= 1'b0;
      r_brk_gap  <= 1'b0;
`endif
    end else if (w_pop) begin
      // Capture the word and its framing together; later config changes
      // affect only the next frame.
      r_shift    <= w_head;
      r_div      <= div;
      r_par_en   <= ^parity_mode;
      r_par_bit  <= (^w_head) ^ (parity_mode == 2'b10);
      r_stop2    <= stop2;
      r_stop_cnt <= 1'b0;
      r_timer    <= '0;
      r_state    <= S_START;
      r_tx       <= 1'b0;
`ifdef SERIAL_TX_BREAK_EN
      r_brk_gap  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
`ifdef SERIAL_TX_BREAK_EN
          if (brk) begin
            r_tx       <= 1'b0;
            r_brk_hold <= 1'b1;
          end else if (r_brk_hold) begin
            r_brk_hold <= 1'b0;
            r_brk_gap  <= 1'b1;
            r_timer    <= '0;
          end else if (w_gap_wait) begin
            r_timer <= r_timer + DivWidth'(1);
          end else begin
            r_brk_gap <= 1'b0;
          end
`endif
        end
        S_START: begin
          if (w_bit_end) begin
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= S_DATA;
          end else begin
            r_timer <= r_timer + DivWidth'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_timer <= '0;
            r_shift <= w_shift_next;
            if (r_bit_idx == LastIdx) begin
              if (r_par_en) begin
                r_tx    <= r_par_bit;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bit_idx <= r_bit_idx + IdxW'(1);
              r_tx      <= w_shift_next[0];
            end
          end else begin
            r_timer <= r_timer + DivWidth'(1);
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_timer <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_timer <= r_timer + DivWidth'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_timer <= '0;
            if (r_stop2 && !r_stop_cnt) begin
              r_stop_cnt <= 1'b1;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_timer <= r_timer + DivWidth'(1);
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Self-checking bench for serial_tx_fifo (Width=8, DivWidth=16, depth 4).
// Each accepted word pushes its expected frame (data plus the framing that
// must apply to it) onto a scoreboard queue. A line monitor pops the head
// entry at every start bit and checks the frame cycle by cycle.
module tb_serial_tx_fifo;

  typedef struct {
    logic [7:0] data;
    int         div;
    logic [1:0] par;
    logic       stop2;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] div;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic [7:0]  d;
  logic        d_valid;
  logic        d_ready;
  logic        tx;
  logic        busy;
  logic [2:0]  level;
`ifdef SERIAL_TX_BREAK_EN
  logic        brk = 1'b0;
`endif

  int     n_checks    = 0;
  int     n_fail      = 0;
  int     frames_done = 0;
  int     gap         = 0;
  frame_t exp_q[$];
  int     gap_q[$];

  serial_tx_fifo #(.Width(8), .DivWidth(16), .FifoDepthLog2(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .div         (div),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .d           (d),
    .d_valid     (d_valid),
`ifdef SERIAL_TX_BREAK_EN
    .brk         (brk),
`endif
    .d_ready     (d_ready),
    .tx          (tx),
    .busy        (busy),
    .level       (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push_word(input logic [7:0] w, input int ediv,
                           input logic [1:0] epar, input logic estop2);
    int     t;
    frame_t e;
    t = 0;
    d = w;
    d_valid = 1'b1;
    while (!d_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("push_accept", d_ready, 1'b1);
    e.data = w; e.div = ediv; e.par = epar; e.stop2 = estop2;
    exp_q.push_back(e);
    @(negedge clk);
    d_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while ((busy || exp_q.size() != 0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("idle_within_budget", (t < budget), 1'b1);
    @(negedge clk);
  endtask

  // Line monitor: samples tx on every falling edge.
  initial begin : line_monitor
    frame_t     e;
    logic       exp_bits [16];
    int         nbits;
    int         glitch;
    logic [7:0] obs;
    logic       obs_par;
    logic       has_par;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        gap = 0;
      end else if (tx === 1'b1) begin
        gap++;
      end else if (exp_q.size() == 0) begin
        check("spurious_start", tx, 1'b1);
      end else begin
        e = exp_q.pop_front();
        gap_q.push_back(gap);
        gap = 0;
        has_par = (e.par == 2'b01) || (e.par == 2'b10);
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[1 + i] = e.data[i];
        nbits = 9;
        if (has_par) begin
          exp_bits[9] = (^e.data) ^ (e.par == 2'b10);
          nbits = 10;
        end
        exp_bits[nbits] = 1'b1;
        nbits++;
        if (e.stop2) begin
          exp_bits[nbits] = 1'b1;
          nbits++;
        end
        glitch = 0; aborted = 1'b0; obs = '0; obs_par = 1'b0;
        for (int b = 0; b < nbits && !aborted; b++) begin
          for (int c = 0; c <= e.div && !aborted; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rst !== 1'b1) begin
              aborted = 1'b1;
            end else begin
              if (tx !== exp_bits[b]) glitch++;
              if (c == 0 && b >= 1 && b <= 8) obs[b-1] = tx;
              if (c == 0 && b == 9 && has_par) obs_par = tx;
            end
          end
        end
        if (!aborted) begin
          check("frame_data", obs, e.data);
          if (has_par) check("frame_parity", obs_par, exp_bits[9]);
          check("frame_shape_errors", glitch, 0);
          frames_done++;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int fd;
    int low;

    rst = 1'b0; div = 16'd3; parity_mode = 2'b00; stop2 = 1'b0;
    d = '0; d_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_level", level, 3'd0);
    check("rst_ready", d_ready, 1'b1);
    rst = 1'b1;
    @(negedge clk);

    // Single 0xA5 frame, div=3, no parity, one stop bit
    push_word(8'hA5, 3, 2'b00, 1'b0);       // accepted at edge k
    check("t1_level_after_push", level, 3'd1);
    check("t1_tx_idle_at_k", tx, 1'b1);
    check("t1_busy_at_k", busy, 1'b1);
    @(negedge clk);                          // after edge k+1
    check("t1_start_at_k1", tx, 1'b0);
    check("t1_level_popped", level, 3'd0);
    repeat (39) @(negedge clk);              // after edge k+40: last stop cycle
    check("t1_busy_last_stop", busy, 1'b1);
    check("t1_tx_last_stop", tx, 1'b1);
    @(negedge clk);                          // after edge k+41
    check("t1_busy_dropped", busy, 1'b0);
    wait_idle(100);

    // div=0 with even, odd and "11" (none) parity
    div = 16'd0;
    parity_mode = 2'b01;
    push_word(8'h07, 0, 2'b01, 1'b0);
    wait_idle(100);
    parity_mode = 2'b10;
    push_word(8'h07, 0, 2'b10, 1'b0);
    wait_idle(100);
    parity_mode = 2'b11;
    push_word(8'hC3, 0, 2'b11, 1'b0);
    wait_idle(100);
    check("t2_frames", frames_done, 4);

    // FIFO fill while the line is busy; back-to-back frames
    div = 16'd3;
    parity_mode = 2'b00;
    gap_q.delete();
    fd = frames_done;
    push_word(8'hF0, 3, 2'b00, 1'b0);
    push_word(8'h11, 3, 2'b00, 1'b0);
    push_word(8'h22, 3, 2'b00, 1'b0);
    push_word(8'h33, 3, 2'b00, 1'b0);
    push_word(8'h44, 3, 2'b00, 1'b0);
    check("t3_level_full", level, 3'd4);
    check("t3_ready_low", d_ready, 1'b0);
    d = 8'h55;
    d_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("t3_write_while_full_ignored", level, 3'd4);
    low = 0;
    while (!d_ready && low < 1000) begin
      @(negedge clk);
      low++;
    end
    check("t3_ready_returns", d_ready, 1'b1);
    check("t3_pop_no_same_cycle_write", level, 3'd3);
    begin
      frame_t e;
      e.data = 8'h55; e.div = 3; e.par = 2'b00; e.stop2 = 1'b0;
      exp_q.push_back(e);
    end
    @(negedge clk);
    d_valid = 1'b0;
    check("t3_level_after_55", level, 3'd4);
    wait_idle(2000);
    check("t3_frames", frames_done - fd, 6);
    for (int i = 1; i < 6; i++) begin
      if (i < gap_q.size()) check("t3_back_to_back_gap", gap_q[i], 0);
      else check("t3_gap_recorded", gap_q.size(), 6);
    end

    // Two stop bits at div=1, then a div change mid-frame
    div = 16'd1;
    stop2 = 1'b1;
    gap_q.delete();
    push_word(8'h00, 1, 2'b00, 1'b1);
    push_word(8'h3C, 9, 2'b00, 1'b1);
    repeat (3) @(negedge clk);
    div = 16'd9;
    wait_idle(1000);
    check("t4_gap_count", gap_q.size(), 2);
    if (gap_q.size() == 2) check("t4_back_to_back_gap", gap_q[1], 0);
    stop2 = 1'b0;
    div = 16'd3;

    // Reset during DATA with two words queued
    fd = frames_done;
    push_word(8'h81, 3, 2'b00, 1'b0);
    push_word(8'h42, 3, 2'b00, 1'b0);
    push_word(8'h24, 3, 2'b00, 1'b0);
    repeat (6) @(negedge clk);
    check("t5_level_before_rst", level, 3'd2);
    check("t5_busy_before_rst", busy, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check("t5_rst_tx", tx, 1'b1);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_level", level, 3'd0);
    check("t5_rst_ready", d_ready, 1'b1);
    @(negedge clk);
    exp_q.delete();
    rst = 1'b1;
    low = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) low++;
    end
    check("t5_line_stays_idle", low, 0);
    check("t5_no_more_frames", frames_done, fd);
    check("t5_level_after", level, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
